uart_txrx_param: RTL

Parametrised full-duplex UART transceiver: the next generation of the fixed 8N1 UART top.
- Configurable data width, parity and stop bits.
- Receiver uses oversampled start-bit validation; receiver reports parity and framing errors.
- Sits between a host-side byte interface and the serial pins; tx and rx are independent and may run concurrently.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_txrx_param.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity modes, FSM state types
// and the parity helper used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

    // Unused upper data bits must be zero so they do not disturb the XOR.
    function automatic logic parity_bit(input int unsigned mode, input logic [8:0] data);
        if (mode == PARITY_EVEN) begin
            return ^data;
        end else if (mode == PARITY_ODD) begin
            return ~^data;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider: one-cycle tick every DIV clocks while en is high;
// the count restarts from zero whenever en is low so ticks align to en rising.
module uart_baud_tick #(
    parameter int unsigned DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 1) begin : g_bad_div
        $error("uart_baud_tick: DIV must be at least 1");
    end

    logic [CW-1:0] cnt_q;
    logic          wrap;

    assign wrap = (cnt_q == CW'(DIV - 1));
    assign tick = en && wrap;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt_q <= '0;
        end else if (wrap) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_txrx_param.sv
// Parametrised full-duplex UART (data width, parity, stop bits, rx oversampling).
// Define UART_LOOPBACK_EN to add a loopback input that routes tx internally to rx.
module uart_txrx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 1_600_000,
    parameter int unsigned BAUD        = 100_000,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned OVERSAMPLE  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef UART_LOOPBACK_EN
    input  logic                 loopback,
`endif
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int unsigned BIT_DIV    = CLK_FREQ / BAUD;
    localparam int unsigned TICK_DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned BCW        = $clog2(DATA_BITS);
    localparam int unsigned TCW        = $clog2(OVERSAMPLE);
    localparam bit          HAS_PARITY = (PARITY_MODE != PARITY_NONE);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_txrx_param: DATA_BITS must be in 5..9");
    end
    if (PARITY_MODE > PARITY_ODD) begin : g_bad_parity
        $error("uart_txrx_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_txrx_param: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_txrx_param: OVERSAMPLE must be even and at least 4");
    end
    if (BAUD == 0 || (CLK_FREQ % (BAUD * OVERSAMPLE)) != 0) begin : g_bad_ratio
        $error("uart_txrx_param: CLK_FREQ must be an integer multiple of BAUD*OVERSAMPLE");
    end

    logic tx_q;
    logic rx_in;

`ifdef UART_LOOPBACK_EN
    assign tx    = loopback ? 1'b1 : tx_q;
    assign rx_in = loopback ? tx_q : rx;
`else
    assign tx    = tx_q;
    assign rx_in = rx;
`endif

    // ---------------------------------------------------------------- transmitter
    tx_state_e            tx_state_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic [BCW-1:0]       tx_bit_q;
    logic                 tx_stop_q;
    logic                 tx_par_q;
    logic                 tx_tick;
    logic                 tx_last;
    logic                 tx_accept;

    uart_baud_tick #(
        .DIV (BIT_DIV)
    ) u_tx_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tx_state_q != TxIdle),
        .tick  (tx_tick)
    );

    // Final cycle of the last stop bit doubles as an idle slot for back-to-back frames.
    assign tx_last   = (tx_state_q == TxStop) && tx_tick && (tx_stop_q == 1'(STOP_BITS - 1));
    assign tx_accept = tx_start && ((tx_state_q == TxIdle) || tx_last);
    assign tx_done   = tx_last;
    assign tx_busy   = (tx_state_q != TxIdle) && !tx_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= TxIdle;
            tx_q       <= 1'b1;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_par_q   <= 1'b0;
        end else if (tx_accept) begin
            tx_state_q <= TxStart;
            tx_q       <= 1'b0;
            tx_shift_q <= tx_data;
            tx_par_q   <= parity_bit(PARITY_MODE, 9'(tx_data));
        end else if (tx_last) begin
            tx_state_q <= TxIdle;
        end else if (tx_tick) begin
            case (tx_state_q)
                TxStart: begin
                    tx_q       <= tx_shift_q[0];
                    tx_shift_q <= tx_shift_q >> 1;
                    tx_bit_q   <= '0;
                    tx_state_q <= TxData;
                end
                TxData: begin
                    if (tx_bit_q == BCW'(DATA_BITS - 1)) begin
                        tx_stop_q <= 1'b0;
                        if (HAS_PARITY) begin
                            tx_q       <= tx_par_q;
                            tx_state_q <= TxParity;
                        end else begin
                            tx_q       <= 1'b1;
                            tx_state_q <= TxStop;
                        end
                    end else begin
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_bit_q   <= tx_bit_q + 1'b1;
                    end
                end
                TxParity: begin
                    tx_q       <= 1'b1;
                    tx_state_q <= TxStop;
                end
                TxStop: tx_stop_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------- receiver
    rx_state_e            rx_state_q;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic [TCW-1:0]       rx_tcnt_q;
    logic [BCW-1:0]       rx_bit_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_par_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_done_q, rx_perr_q, rx_ferr_q;
    logic                 rx_tick;
    logic                 rx_mid;
    logic                 rx_sample;

    uart_baud_tick #(
        .DIV (TICK_DIV)
    ) u_rx_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rx_state_q != RxIdle),
        .tick  (rx_tick)
    );

    assign rx_mid    = rx_tick && (rx_tcnt_q == TCW'(OVERSAMPLE / 2 - 1));
    assign rx_sample = rx_tick && (rx_tcnt_q == TCW'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q <= RxIdle;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_tcnt_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_s1_q   <= rx_in;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_done_q <= 1'b0;
            if (rx_state_q != RxIdle && rx_tick && !rx_mid && !rx_sample) begin
                rx_tcnt_q <= rx_tcnt_q + 1'b1;
            end
            unique case (rx_state_q)
                RxIdle: begin
                    rx_tcnt_q <= '0;
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_state_q <= RxStart;
                    end
                end
                RxStart: begin
                    if (rx_mid) begin
                        rx_tcnt_q  <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s2_q ? RxIdle : RxData;
                    end else if (rx_sample) begin
                        rx_tcnt_q <= rx_tcnt_q + 1'b1;
                    end
                end
                RxData: begin
                    if (rx_sample) begin
                        rx_tcnt_q  <= '0;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == BCW'(DATA_BITS - 1)) begin
                            rx_state_q <= HAS_PARITY ? RxParity : RxStop;
                        end else begin
                            rx_bit_q <= rx_bit_q + 1'b1;
                        end
                    end else if (rx_mid) begin
                        rx_tcnt_q <= rx_tcnt_q + 1'b1;
                    end
                end
                RxParity: begin
                    if (rx_sample) begin
                        rx_tcnt_q  <= '0;
                        rx_par_q   <= rx_s2_q;
                        rx_state_q <= RxStop;
                    end else if (rx_mid) begin
                        rx_tcnt_q <= rx_tcnt_q + 1'b1;
                    end
                end
                RxStop: begin
                    if (rx_sample) begin
                        rx_data_q  <= rx_shift_q;
                        rx_perr_q  <= HAS_PARITY &&
                                      (rx_par_q != parity_bit(PARITY_MODE, 9'(rx_shift_q)));
                        rx_ferr_q  <= !rx_s2_q;
                        rx_done_q  <= 1'b1;
                        rx_state_q <= RxIdle;
                    end else if (rx_mid) begin
                        rx_tcnt_q <= rx_tcnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_done       = rx_done_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;

endmodule
